source_sweep_ctrl: RTL and testbench
====================================

Name: source_sweep_ctrl

Overview:
Sweep sequencer for the controlled/AC source bank (VCCS/VCVS/CCVS/CCCS gain, IAC/VAC amplitude).
- Holds a per-source start value and step value.
- On each sweep point, writes the current value of every enabled source over a valid/ready bus, waits a programmable settle time, then requests one measurement from the analysis engine.
- Sits between the host configuration interface and the source parameter registers.

Parameters:
NSRC, 4, number of sources controlled (≥1)
VW, 16, width of signed source value (gain/amplitude code)
CW, 12, width of point count and settle counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe; ignored while busy
cfg_addr  in  max(1,$clog2(NSRC))  source index for config write
cfg_en  in  1  source enable
cfg_start  in  VW  signed start value
cfg_step  in  VW  signed per-point increment
npts  in  CW  number of sweep points; sampled at start
settle  in  CW  settle cycles per point; sampled at start
start  in  1  single-cycle sweep start
abort  in  1  cancel the sweep
wr_valid  out  1  source write valid
wr_ready  in  1  source write accept
wr_sel  out  max(1,$clog2(NSRC))  source index being written
wr_data  out  VW  value being written
meas_req  out  1  measurement request
meas_ack  in  1  measurement complete
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal completion
point_idx  out  CW  current point index k
sat  out  1  sticky: an accumulator saturated during this sweep

Behaviour:
- Reset (async, rst_n=0) clears all cfg regs (en=0, start=0, step=0), accumulators, counters and state. Outputs: wr_valid=0, wr_sel=0, wr_data=0, meas_req=0, busy=0, done=0, point_idx=0, sat=0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, APPLY, SETTLE, MEAS, NEXT, DONE.
- IDLE:
  - cfg_we writes en/start/step for cfg_addr. An out-of-range cfg_addr is ignored.
  - On start: latch npts and settle, set acc[i]=start[i], k=0, clear sat.
    - npts==0: go to DONE (no writes, no meas).
    - Otherwise: set busy=1 and go to APPLY with scan index i=0.
  - abort and start in the same cycle: abort wins, stay IDLE.
- APPLY: one cycle per index i=0..NSRC-1.
  - Disabled i: no output, advance i.
  - Enabled i: assert wr_valid with wr_sel=i and wr_data=acc[i]. These are held stable until wr_valid&&wr_ready at a clock edge, then advance i.
  - Back-to-back enabled sources give one transfer per cycle when wr_ready is held high: wr_valid stays high and sel/data update after each edge.
  - After i=NSRC-1 go to SETTLE. If no source is enabled, APPLY takes NSRC cycles with no transfers.
- SETTLE: wait exactly `settle` cycles; settle==0 → go directly to MEAS on the next edge.
- MEAS:
  - meas_req=1 until meas_ack is sampled high, then meas_req drops the next cycle.
  - meas_ack outside MEAS is ignored.
- NEXT (one cycle):
  - If k==npts-1 → DONE.
  - Otherwise: acc[i]=sat_add(acc[i],step[i]) for all i, k=k+1, go to APPLY.
  - sat_add is signed VW-bit with clamping to [-2^(VW-1), 2^(VW-1)-1]. Any clamp sets sat (sticky until the next start).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing of outputs:
  - busy is high from the cycle after start through the last NEXT, and low in DONE.
  - point_idx=k is valid throughout each point.
- abort:
  - In any non-IDLE state: go to IDLE at the next edge. wr_valid and meas_req deassert without completing their handshakes; there is no done pulse.
  - sat and point_idx hold their values; cfg regs are untouched.
- start while busy is ignored. cfg_we while busy is ignored.

Test Plan:
- Reset check: hold rst_n low mid-APPLY → all outputs 0 asynchronously. Release, then read back through a sweep → cfg cleared.
- Basic 2-source sweep: NSRC=4, src0 en start=100 step=10, src2 en start=-5 step=-5, npts=3, settle=2, wr_ready=1, meas_ack one cycle after req → writes (0,100),(2,-5),(0,110),(2,-10),(0,120),(2,-15); 3 meas_req; done once; busy low after.
- Backpressure: wr_ready low for 4 cycles on the first write → wr_valid/wr_sel/wr_data stable for 4 cycles; no dropped or duplicate write.
- Saturation: src1 start=32760 step=5, npts=3 → writes 32760, 32765, 32767; sat=1 after the second NEXT.
- Edge counts:
  - npts=0 → done the cycle after start, no wr_valid, no meas_req.
  - npts=1 with no sources enabled and settle=0 → a single meas_req, then done.
- Abort: abort while meas_req is high on point 1 → IDLE next cycle, meas_req=0, no done; a new start with the same config restarts at acc=start and k=0.

Source files
------------

// File: rtl/source_sweep_ctrl.sv
// rtl/source_sweep_ctrl.sv - sweep sequencer for the controlled/AC source bank
//
// Steps every enabled source through start + k*step (saturating) for npts
// points. For each point it writes the enabled sources over a valid/ready bus,
// waits `settle` cycles, then requests one measurement.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/addr/en/       per-source configuration write (IDLE only)
//   cfg_start/cfg_step
//   npts, settle          sweep length and settle cycles, sampled at start
//   start, abort          sweep start pulse, sweep cancel (abort wins)
//   wr_valid/ready/       source write bus
//   wr_sel/wr_data
//   meas_req, meas_ack    measurement handshake
//   busy, done            sweep in progress, one-cycle completion pulse
//   point_idx, sat        current point index, sticky saturation flag
module source_sweep_ctrl #(
  parameter int NSRC = 4,
  parameter int VW   = 16,
  parameter int CW   = 12,
  localparam int AW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic                 cfg_en,
  input  logic signed [VW-1:0] cfg_start,
  input  logic signed [VW-1:0] cfg_step,
  input  logic [CW-1:0]        npts,
  input  logic [CW-1:0]        settle,
  input  logic                 start,
  input  logic                 abort,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [AW-1:0]        wr_sel,
  output logic signed [VW-1:0] wr_data,
  output logic                 meas_req,
  input  logic                 meas_ack,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        point_idx,
  output logic                 sat
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_MEAS, S_NEXT, S_DONE
  } state_t;

  state_t                r_state;
  logic [NSRC-1:0]       r_en;
  logic signed [VW-1:0]  r_start [NSRC];
  logic signed [VW-1:0]  r_step  [NSRC];
  logic signed [VW-1:0]  r_acc   [NSRC];
  logic [CW-1:0]         r_npts;
  logic [CW-1:0]         r_settle;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_k;
  logic [AW-1:0]         r_idx;
  logic                  r_wr_valid;
  logic [AW-1:0]         r_wr_sel;
  logic signed [VW-1:0]  r_wr_data;
  logic                  r_meas_req;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sat;

  logic [VW:0]           w_sum    [NSRC];
  logic signed [VW-1:0]  w_acc_nx [NSRC];
  logic [NSRC-1:0]       w_ovf;
  logic [AW-1:0]         w_idx_inc;
  logic                  w_last_idx;
  logic                  w_cfg_ok;

  // Saturating add: one guard bit detects signed overflow, the guard bit's
  // sign picks which rail to clamp to.
  for (genvar g = 0; g < NSRC; g++) begin : g_sat
    assign w_sum[g]    = {r_acc[g][VW-1], r_acc[g]} + {r_step[g][VW-1], r_step[g]};
    assign w_ovf[g]    = w_sum[g][VW] ^ w_sum[g][VW-1];
    assign w_acc_nx[g] = !w_ovf[g]     ? w_sum[g][VW-1:0] :
                         w_sum[g][VW]  ? {1'b1, {(VW-1){1'b0}}} :
                                         {1'b0, {(VW-1){1'b1}}};
  end

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_last_idx = (r_idx == AW'(NSRC - 1));
  assign w_cfg_ok   = (int'(cfg_addr) < NSRC);

  // Outputs are registered one cycle ahead: whenever a transition enters an
  // APPLY slot, the write bus for that slot is loaded on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_en       <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_start[i] <= '0;
        r_step[i]  <= '0;
        r_acc[i]   <= '0;
      end
      r_npts     <= '0;
      r_settle   <= '0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_idx      <= '0;
      r_wr_valid <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_meas_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
    end else if (abort && r_state != S_IDLE) begin
      // Drop handshakes mid-flight; sat, point_idx and cfg are preserved.
      r_state    <= S_IDLE;
      r_wr_valid <= 1'b0;
      r_meas_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (cfg_we && w_cfg_ok) begin
            r_en[cfg_addr]    <= cfg_en;
            r_start[cfg_addr] <= cfg_start;
            r_step[cfg_addr]  <= cfg_step;
          end
          if (start && !abort) begin
            r_npts   <= npts;
            r_settle <= settle;
            r_k      <= '0;
            r_sat    <= 1'b0;
            for (int i = 0; i < NSRC; i++) r_acc[i] <= r_start[i];
            if (npts == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_APPLY;
              r_busy     <= 1'b1;
              r_idx      <= '0;
              r_wr_valid <= r_en[0];
              r_wr_sel   <= '0;
              r_wr_data  <= r_start[0];
            end
          end
        end

        S_APPLY: begin
          // Advance when the slot is disabled or its transfer completes.
          if (!r_wr_valid || wr_ready) begin
            if (w_last_idx) begin
              r_wr_valid <= 1'b0;
              if (r_settle == '0) begin
                r_state    <= S_MEAS;
                r_meas_req <= 1'b1;
              end else begin
                r_state <= S_SETTLE;
                r_cnt   <= r_settle;
              end
            end else begin
              r_idx      <= w_idx_inc;
              r_wr_valid <= r_en[w_idx_inc];
              r_wr_sel   <= w_idx_inc;
              r_wr_data  <= r_acc[w_idx_inc];
            end
          end
        end

        S_SETTLE: begin
          if (r_cnt == CW'(1)) begin
            r_state    <= S_MEAS;
            r_meas_req <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_MEAS: begin
          if (meas_ack) begin
            r_meas_req <= 1'b0;
            r_state    <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (r_k == r_npts - CW'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            for (int i = 0; i < NSRC; i++) r_acc[i] <= w_acc_nx[i];
            if (|w_ovf) r_sat <= 1'b1;
            r_k        <= r_k + 1'b1;
            r_state    <= S_APPLY;
            r_idx      <= '0;
            r_wr_valid <= r_en[0];
            r_wr_sel   <= '0;
            r_wr_data  <= w_acc_nx[0];
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_valid  = r_wr_valid;
  assign wr_sel    = r_wr_sel;
  assign wr_data   = r_wr_data;
  assign meas_req  = r_meas_req;
  assign busy      = r_busy;
  assign done      = r_done;
  assign point_idx = r_k;
  assign sat       = r_sat;

endmodule

// File: tb/tb_source_sweep_ctrl.sv
// tb/tb_source_sweep_ctrl.sv - self-checking bench for source_sweep_ctrl
module tb_source_sweep_ctrl;
  localparam int NSRC = 4;
  localparam int VW   = 16;
  localparam int CW   = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic                 cfg_en;
  logic signed [VW-1:0] cfg_start;
  logic signed [VW-1:0] cfg_step;
  logic [CW-1:0]        npts;
  logic [CW-1:0]        settle;
  logic                 start;
  logic                 abort;
  logic                 wr_valid;
  logic                 wr_ready = 1'b1;
  logic [1:0]           wr_sel;
  logic signed [VW-1:0] wr_data;
  logic                 meas_req;
  logic                 meas_ack = 1'b0;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        point_idx;
  logic                 sat;

  always #5 clk = ~clk;

  source_sweep_ctrl #(.NSRC(NSRC), .VW(VW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_start(cfg_start), .cfg_step(cfg_step),
    .npts(npts), .settle(settle), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .meas_req(meas_req), .meas_ack(meas_ack),
    .busy(busy), .done(done), .point_idx(point_idx), .sat(sat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- environment: ack responder, ready driver, monitor -------
  bit ack_next = 1'b0;
  always @(negedge clk) ack_next = meas_req && !meas_ack;
  always @(posedge clk) begin
    #1;
    meas_ack = ack_next;
  end

  int ready_mode    = 0;  // 0 high, 1 random, 2 low
  int ready_low_cnt = 0;  // stall this many cycles while wr_valid is high
  always @(posedge clk) begin
    #1;
    if (ready_low_cnt > 0 && wr_valid) begin
      wr_ready = 1'b0;
      ready_low_cnt--;
    end else if (ready_mode == 2) wr_ready = 1'b0;
    else if (ready_mode == 1)     wr_ready = 1'($urandom_range(0, 1));
    else                          wr_ready = 1'b1;
  end

  typedef struct { int sel; int data; } wr_t;
  wr_t  got_q[$];
  bit   mon_on = 1'b0;
  int   meas_cnt, done_cnt, busy_cyc, stall_cyc, valid_cyc, mon_cyc, first_done;
  bit   prev_stall = 1'b0;
  int   prev_sel, prev_data;

  always @(negedge clk) begin
    if (mon_on) begin
      mon_cyc++;
      if (wr_valid && wr_ready) got_q.push_back('{int'(wr_sel), int'(wr_data)});
      if (wr_valid) valid_cyc++;
      if (wr_valid && !wr_ready) stall_cyc++;
      if (meas_req && meas_ack) meas_cnt++;
      if (busy) busy_cyc++;
      if (done) begin
        if (done_cnt == 0) first_done = mon_cyc;
        done_cnt++;
      end
      if (prev_stall) begin
        chk("hold.valid", wr_valid, 1);
        chk("hold.sel", wr_sel, prev_sel);
        chk("hold.data", wr_data, prev_data);
      end
    end
    prev_stall = mon_on && wr_valid && !wr_ready;
    prev_sel   = int'(wr_sel);
    prev_data  = int'(wr_data);
  end

  // ---------------- reference model ----------------------------------------
  int m_en[NSRC], m_start[NSRC], m_step[NSRC];

  function automatic int clampv(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Point j of source i is start + j*step clamped to range; with a constant
  // step this equals the repeatedly-clamped accumulator.
  task automatic check_sweep(input string tag, input int n);
    wr_t exp_q[$];
    bit  exp_sat = 1'b0;
    int  m;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < NSRC; i++)
        if (m_en[i] != 0)
          exp_q.push_back('{i, clampv(longint'(m_start[i]) + longint'(j) * longint'(m_step[i]))});
    if (n > 1)
      for (int i = 0; i < NSRC; i++) begin
        longint v = longint'(m_start[i]) + longint'(n - 1) * longint'(m_step[i]);
        if (v > 32767 || v < -32768) exp_sat = 1'b1;
      end
    chk($sformatf("%s.nwr", tag), got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s.wr%0d.sel", tag, k), got_q[k].sel, exp_q[k].sel);
      chk($sformatf("%s.wr%0d.data", tag, k), got_q[k].data, exp_q[k].data);
    end
    chk($sformatf("%s.meas", tag), meas_cnt, n);
    chk($sformatf("%s.done", tag), done_cnt, 1);
    chk($sformatf("%s.sat", tag), sat, exp_sat);
    chk($sformatf("%s.pidx", tag), point_idx, (n == 0) ? 0 : n - 1);
    chk($sformatf("%s.busy_end", tag), busy, 0);
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cfg_write(input int a, input int en, input int st, input int sp);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_en = 1'(en);
    cfg_start = 16'(st); cfg_step = 16'(sp);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic program_model();
    for (int i = 0; i < NSRC; i++) cfg_write(i, m_en[i], m_start[i], m_step[i]);
  endtask

  task automatic clear_mon();
    got_q.delete();
    meas_cnt = 0; done_cnt = 0; busy_cyc = 0; stall_cyc = 0;
    valid_cyc = 0; mon_cyc = 0; first_done = 0;
  endtask

  task automatic do_sweep(input string tag, input int n, input int st, input int budget);
    clear_mon();
    npts = CW'(n); settle = CW'(st);
    @(posedge clk); #1;
    start = 1'b1; mon_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
    @(negedge clk); @(negedge clk);
    mon_on = 1'b0;
    if (done_cnt == 0) begin
      chk({tag, ".timeout"}, 0, 1);
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
    end
  endtask

  task automatic set_basic();
    m_en    = '{1, 0, 1, 0};
    m_start = '{100, 0, -5, 0};
    m_step  = '{10, 0, -5, 0};
  endtask

  // ---------------- vector table --------------------------------------------
  typedef struct {
    string name;
    int    en[NSRC];
    int    st[NSRC];
    int    sp[NSRC];
    int    n;
    int    settle;
    int    exp_nwr;
    int    exp_last_sel;
    int    exp_last_data;
    int    exp_sat;
    int    exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"basic", '{1,0,1,0}, '{100,0,-5,0}, '{10,0,-5,0}, 3, 2, 6, 2, -15, 0, 27};
    vecs[1] = '{"satpos", '{0,1,0,0}, '{0,32760,0,0}, '{0,5,0,0}, 3, 0, 3, 1, 32767, 1, 21};
    vecs[2] = '{"noen", '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, 1, 0, 0, 0, 0, 0, 7};
    vecs[3] = '{"satneg", '{0,0,0,1}, '{0,0,0,-32760}, '{0,0,0,-8}, 4, 1, 4, 3, -32768, 1, 32};
    vecs[4] = '{"all4", '{1,1,1,1}, '{1,2,3,4}, '{1,1,1,1}, 2, 3, 8, 3, 5, 0, 20};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0;
    cfg_start = '0; cfg_step = '0; npts = '0; settle = '0;
    start = 1'b0; abort = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.wr_valid", wr_valid, 0); chk("rst.wr_sel", wr_sel, 0);
    chk("rst.wr_data", wr_data, 0);   chk("rst.meas_req", meas_req, 0);
    chk("rst.busy", busy, 0);         chk("rst.done", done, 0);
    chk("rst.pidx", point_idx, 0);    chk("rst.sat", sat, 0);
    rst_n = 1'b1;

    // Table-driven sweeps, wr_ready held high
    foreach (vecs[v]) begin
      for (int i = 0; i < NSRC; i++) begin
        m_en[i] = vecs[v].en[i]; m_start[i] = vecs[v].st[i]; m_step[i] = vecs[v].sp[i];
      end
      program_model();
      do_sweep(vecs[v].name, vecs[v].n, vecs[v].settle, 400);
      check_sweep(vecs[v].name, vecs[v].n);
      chk({vecs[v].name, ".tbl_nwr"}, got_q.size(), vecs[v].exp_nwr);
      if (vecs[v].exp_nwr > 0) begin
        chk({vecs[v].name, ".tbl_sel"}, got_q[got_q.size()-1].sel, vecs[v].exp_last_sel);
        chk({vecs[v].name, ".tbl_data"}, got_q[got_q.size()-1].data, vecs[v].exp_last_data);
      end
      chk({vecs[v].name, ".tbl_sat"}, sat, vecs[v].exp_sat);
      chk({vecs[v].name, ".tbl_busy"}, busy_cyc, vecs[v].exp_busy);
    end

    // Backpressure: first write stalled 4 cycles
    set_basic(); program_model();
    ready_low_cnt = 4;
    do_sweep("bp", 3, 2, 400);
    check_sweep("bp", 3);
    chk("bp.stalls", stall_cyc, 4);
    chk("bp.busy", busy_cyc, 31);

    // npts == 0: done in the cycle after start, nothing else
    do_sweep("n0", 0, 2, 50);
    check_sweep("n0", 0);
    chk("n0.done_cyc", first_done, 2);
    chk("n0.valid", valid_cyc, 0);
    chk("n0.busy", busy_cyc, 0);

    // abort together with start: stays idle
    @(posedge clk); #1; npts = 12'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abst.busy", busy, 0); chk("abst.wr_valid", wr_valid, 0); chk("abst.done", done, 0);

    // Abort while meas_req is high on point 1, then restart
    begin
      bit seen = 1'b0;
      clear_mon();
      npts = 12'd3; settle = 12'd2;
      @(posedge clk); #1; start = 1'b1; mon_on = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        seen = meas_req && (point_idx == 12'd1);
      end
      chk("abt.reached", seen, 1);
      @(posedge clk); #1; abort = 1'b1;
      @(negedge clk);
      chk("abt.req_before", meas_req, 1);
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      chk("abt.req", meas_req, 0); chk("abt.busy", busy, 0);
      chk("abt.wr_valid", wr_valid, 0); chk("abt.pidx", point_idx, 1);
      @(negedge clk);
      chk("abt.no_done", done_cnt, 0);
      mon_on = 1'b0;
      do_sweep("abt_re", 3, 2, 400);
      check_sweep("abt_re", 3);
    end

    // Asynchronous reset mid-APPLY, then config must read back cleared
    m_en = '{1, 0, 0, 0}; m_start = '{77, 0, 0, 0}; m_step = '{1, 0, 0, 0};
    program_model();
    ready_mode = 2;
    npts = 12'd2; settle = 12'd1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ra.pre_valid", wr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra.wr_valid", wr_valid, 0); chk("ra.wr_data", wr_data, 0);
    chk("ra.busy", busy, 0);         chk("ra.meas_req", meas_req, 0);
    chk("ra.done", done, 0);         chk("ra.pidx", point_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    m_en = '{0, 0, 0, 0}; m_start = '{0, 0, 0, 0}; m_step = '{0, 0, 0, 0};
    do_sweep("ra_clr", 2, 1, 100);
    check_sweep("ra_clr", 2);

    // Randomized sweeps with random backpressure
    ready_mode = 1;
    for (int it = 0; it < 16; it++) begin
      int n;
      for (int i = 0; i < NSRC; i++) begin
        m_en[i] = int'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       m_start[i] = 32700 + int'($urandom_range(0, 67));
          1:       m_start[i] = -32700 - int'($urandom_range(0, 68));
          default: m_start[i] = int'($urandom_range(0, 4000)) - 2000;
        endcase
        if ($urandom_range(0, 2) == 0) m_step[i] = int'($urandom_range(0, 40000)) - 20000;
        else                           m_step[i] = int'($urandom_range(0, 40)) - 20;
      end
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      program_model();
      do_sweep($sformatf("rnd%0d", it), n, int'($urandom_range(0, 3)), 600);
      check_sweep($sformatf("rnd%0d", it), n);
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

endmodule
